// File: rtl/ntt_fifo_loader.sv
// Streams N coefficient pairs into two lock-stepped FIFOs, tagging each word with its accept-order address.
// Optional blocked-write counter is compiled in with `define NTT_LOADER_STALL_CNT_EN.
module ntt_fifo_loader #(
  parameter int N  = 256,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data_a,
  input  logic [DW-1:0] in_data_b,
  output logic          in_ready,
  input  logic          wr_full1,
  input  logic          wr_full2,
  output logic          wr_req,
  output logic [31:0]   wr_dat1,
  output logic [31:0]   wr_dat2,
  output logic          busy,
  output logic          load_done,
  output logic [15:0]   stall_cnt
);

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_e;

  localparam logic [8:0] NCNT = 9'(N);

  state_e      state_q, state_d;
  logic        hold_v_q, hold_v_d;
  logic [31:0] dat1_q, dat1_d;
  logic [31:0] dat2_q, dat2_d;
  logic [8:0]  acc_cnt_q, acc_cnt_d;
  logic [8:0]  wr_cnt_q, wr_cnt_d;
  logic        busy_q, busy_d;
  logic        load_done_q, load_done_d;
  logic        wr_fire, accept;

  // The hold slot can be refilled in the same cycle it drains, so a full stream costs no bubbles.
  assign wr_fire  = hold_v_q & ~wr_full1 & ~wr_full2;
  assign in_ready = (state_q == LOAD) && (acc_cnt_q < NCNT) && (!hold_v_q || wr_fire);
  assign accept   = in_valid & in_ready;

  assign wr_req    = wr_fire;
  assign wr_dat1   = dat1_q;
  assign wr_dat2   = dat2_q;
  assign busy      = busy_q;
  assign load_done = load_done_q;

  always_comb begin
    state_d   = state_q;
    hold_v_d  = hold_v_q;
    dat1_d    = dat1_q;
    dat2_d    = dat2_q;
    acc_cnt_d = acc_cnt_q;
    wr_cnt_d  = wr_cnt_q;

    if (accept) begin
      hold_v_d  = 1'b1;
      dat1_d    = {8'h00, acc_cnt_q[7:0], 16'(in_data_a)};
      dat2_d    = {8'h00, acc_cnt_q[7:0], 16'(in_data_b)};
      acc_cnt_d = acc_cnt_q + 9'd1;
    end else if (wr_fire) begin
      hold_v_d = 1'b0;
    end
    if (wr_fire) wr_cnt_d = wr_cnt_q + 9'd1;

    case (state_q)
      IDLE:  if (start) state_d = LOAD;
      LOAD: begin
        if (wr_cnt_d == NCNT)       state_d = DONE;
        else if (acc_cnt_d == NCNT) state_d = DRAIN;
      end
      DRAIN: if (wr_cnt_d == NCNT) state_d = DONE;
      DONE: begin
        state_d   = IDLE;
        acc_cnt_d = '0;
        wr_cnt_d  = '0;
      end
      default: state_d = IDLE;
    endcase

    busy_d      = (state_d == LOAD) || (state_d == DRAIN);
    load_done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      hold_v_q    <= 1'b0;
      dat1_q      <= '0;
      dat2_q      <= '0;
      acc_cnt_q   <= '0;
      wr_cnt_q    <= '0;
      busy_q      <= 1'b0;
      load_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_v_q    <= hold_v_d;
      dat1_q      <= dat1_d;
      dat2_q      <= dat2_d;
      acc_cnt_q   <= acc_cnt_d;
      wr_cnt_q    <= wr_cnt_d;
      busy_q      <= busy_d;
      load_done_q <= load_done_d;
    end
  end

`ifdef NTT_LOADER_STALL_CNT_EN
  logic [15:0] stall_q, stall_d;

  // Only a start that actually launches a load clears the count; saturates rather than wraps.
  always_comb begin
    stall_d = stall_q;
    if (state_q == IDLE && start)
      stall_d = '0;
    else if (hold_v_q && (wr_full1 || wr_full2) && stall_q != 16'hFFFF)
      stall_d = stall_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) stall_q <= '0;
    else      stall_q <= stall_d;
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: doc/ntt_fifo_loader.md
NTT_FIFO_LOADER -- requirements
Module: ntt_fifo_loader

Interface
REQ-001 SHALL have parameter N, default 256, number of coefficient pairs per transform (power of 2, 2..256).
REQ-002 SHALL have parameter DW, default 16, coefficient width.
REQ-003 SHALL have port clk  input  1  single clock; all logic rising-edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  one-cycle pulse to begin a load of N pairs.
REQ-006 SHALL have port in_valid  input  1  source has a coefficient pair.
REQ-007 SHALL have port in_data_a  input  DW  coefficient destined for FIFO 1 (bank A).
REQ-008 SHALL have port in_data_b  input  DW  coefficient destined for FIFO 2 (bank B).
REQ-009 SHALL have port in_ready  output  1  pair accepted when in_valid and in_ready are both high at a rising edge.
REQ-010 SHALL have port wr_full1  input  1  FIFO 1 write-side full.
REQ-011 SHALL have port wr_full2  input  1  FIFO 2 write-side full.
REQ-012 SHALL have port wr_req  output  1  write strobe shared by both FIFOs.
REQ-013 SHALL have port wr_dat1  output  32  FIFO 1 word: [31:24]=0, [23:16]=address, [15:0]=in_data_a.
REQ-014 SHALL have port wr_dat2  output  32  FIFO 2 word: same layout, carrying in_data_b.
REQ-015 SHALL have port busy  output  1  high in LOAD and DRAIN.
REQ-016 SHALL have port load_done  output  1  one-cycle pulse after the Nth FIFO write.
REQ-017 SHALL have port stall_cnt  output  16  blocked-write cycle count (see Configuration).

Function
REQ-018 SHALL implement FSM states IDLE, LOAD, DRAIN, DONE.
REQ-019 IDLE->LOAD on start; start in any other state SHALL be ignored.
REQ-020 SHALL hold one pending word (hold register, hold_v flag).
REQ-021 in_ready SHALL be high iff state==LOAD and accepted count < N and (hold_v==0 or a write occurs this cycle).
REQ-022 On accept SHALL load hold with {8'h00, acc_cnt[7:0], data}, set hold_v, increment acc_cnt; address = accept order, 0..N-1.
REQ-023 wr_req SHALL be combinational: hold_v & ~wr_full1 & ~wr_full2; both FIFOs always written together.
REQ-024 wr_dat1/wr_dat2 SHALL be driven from the hold register; a pair accepted at edge k SHALL appear with wr_req high in cycle k+1 when neither FIFO is full.
REQ-025 On a write without a simultaneous accept, hold_v SHALL clear; a simultaneous write and accept SHALL replace the hold contents with no bubble, sustaining one pair per cycle.
REQ-026 While either FIFO is full, hold contents SHALL remain stable and in_ready SHALL be low.
REQ-027 LOAD->DRAIN when acc_cnt reaches N; DRAIN->DONE on the Nth write (wr_cnt==N); the N==1-write edge case SHALL go directly through the same path.
REQ-028 DONE SHALL assert load_done for exactly one cycle, clear counters, then return to IDLE.
REQ-029 acc_cnt and wr_cnt SHALL be 9 bits and never wrap within a load.
REQ-030 in_valid in IDLE, DRAIN, or DONE SHALL be ignored without acceptance.

Reset
REQ-031 rst low SHALL asynchronously force state IDLE, hold_v=0, acc_cnt=0, wr_cnt=0, stall_cnt=0, wr_dat1=wr_dat2=0.
REQ-032 During reset, outputs SHALL be in_ready=0, wr_req=0, busy=0, load_done=0.
REQ-033 Reset during LOAD/DRAIN SHALL discard the pending word; no wr_req SHALL be issued until a new start.

Configuration
REQ-034 Macro NTT_LOADER_STALL_CNT_EN SHALL control stall counting.
REQ-035 When NTT_LOADER_STALL_CNT_EN is defined, stall_cnt SHALL increment each cycle hold_v=1 and (wr_full1|wr_full2), saturate at 16'hFFFF, and clear on start.
REQ-036 When NTT_LOADER_STALL_CNT_EN is undefined, stall_cnt SHALL be constant 0 and no counter logic SHALL be present.

Verification
REQ-037 N=256, in_valid held high, fulls low, start -> 256 wr_req cycles back-to-back starting 2 cycles after start; addresses 0x00..0xFF; load_done one cycle after the last write.
REQ-038 Input pair (0x1234,0xABCD) as 6th pair -> wr_dat1=0x00051234, wr_dat2=0x0005ABCD.
REQ-039 wr_full2 high for 5 cycles mid-load -> wr_req=0, wr_dat stable, in_ready=0 for those cycles; no loss or duplication; stall_cnt=5 with macro, 0 without.
REQ-040 start pulsed again during LOAD -> ignored; exactly N writes; single load_done.
REQ-041 rst low after 100 accepts -> all outputs reset immediately; new start -> addresses restart at 0x00.
REQ-042 N=4, in_valid toggled every other cycle -> 4 writes, addresses 0..3, load_done once, FSM returns to IDLE.
